// File: rtl/serial_add_ctrl_pkg.sv
// Shared types for the bit-serial add/subtract controller: state encoding
// and the operand width range check.
package serial_add_ctrl_pkg;

  localparam int unsigned WIDTH_MIN = 2;
  localparam int unsigned WIDTH_MAX = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic bit width_ok(input int unsigned w);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Operand/result bundle between the operand source and the serial adder.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic             clr;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, sub, clr, a, b,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, sub, clr, a, b,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_add_ctrl_fa_slice.sv
// Combinational 1-bit full adder from two half-adder stages; carry is the OR
// of the two stage carries.
module serial_fa_slice (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  logic p1, g1, g2;

  assign p1 = x ^ y;
  assign g1 = x & y;
  assign s  = p1 ^ ci;
  assign g2 = p1 & ci;
  assign co = g1 | g2;
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: one shared full-adder slice walks the
// operands LSB-first, one bit per clock, then pulses done for one cycle.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_add_ctrl_if.slave   bus
);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("serial_add_ctrl: WIDTH out of range 2..32");
  end

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fa_s, fa_co;

  serial_fa_slice u_fa (
    .x  (a_sr_q[0]),
    .y  (b_sr_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    cnt_d    = cnt_q;
    // clr beats both a new start and RUN completion; result regs untouched
    if (bus.clr) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_sr_d  = bus.a;
            b_sr_d  = bus.sub ? ~bus.b : bus.b;
            carry_d = bus.sub;
            cnt_d   = '0;
            state_d = RUN;
          end
        end
        RUN: begin
          a_sr_d   = a_sr_q >> 1;
          b_sr_d   = b_sr_q >> 1;
          sum_sr_d = {fa_s, sum_sr_q[WIDTH-1:1]};
          carry_d  = fa_co;
          cnt_d    = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            sum_d   = {fa_s, sum_sr_q[WIDTH-1:1]};
            cout_d  = fa_co;
            cnt_d   = '0;
            state_d = DONE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule
